pipe_reg: RTL and testbench

PIPE_REG -- requirements
Module: pipe_reg

---
 rtl/pipe_reg.sv | 85 ++++++++
 tb/tb_pipe_reg.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg.sv
// Pipeline stage register with stall, flush (bubble) and exception-redirect.
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   en, flush, req    - advance, insert bubble, exception/interrupt redirect
//   in_valid, in_pc, in_data, in_exc, new_exc, in_bd - upstream slot contents
//   out_valid, out_pc, out_data, out_exc, out_bd     - registered slot contents
//   out_pcp8          - out_pc + 8 (combinational, wraps mod 2^32)
//   stall_cnt         - consecutive stalled cycles of a valid slot (saturating)
module pipe_reg #(
    parameter int unsigned DW     = 32,
    parameter int unsigned EXC_W  = 5,
    parameter int unsigned CW     = 4,
    parameter logic [31:0] PC_RST = 32'h0000_3000,
    parameter logic [31:0] EXC_PC = 32'h0000_4180
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             req,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [DW-1:0]    in_data,
    input  logic [EXC_W-1:0] in_exc,
    input  logic [EXC_W-1:0] new_exc,
    input  logic             in_bd,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [DW-1:0]    out_data,
    output logic [EXC_W-1:0] out_exc,
    output logic             out_bd,
    output logic [31:0]      out_pcp8,
    output logic [CW-1:0]    stall_cnt
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    // Exception code captured on load: older exception wins; empty slots carry none.
    logic [EXC_W-1:0] load_exc;
    always_comb begin
        load_exc = '0;
        if (in_valid) begin
            load_exc = (in_exc != '0) ? in_exc : new_exc;
        end
    end

    // Stage register: reset > req > flush > load > hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_pc    <= PC_RST;
            out_data  <= '0;
            out_exc   <= '0;
            out_bd    <= 1'b0;
            stall_cnt <= '0;
        end else if (req) begin
            out_valid <= 1'b0;
            out_pc    <= EXC_PC;
            out_data  <= '0;
            out_exc   <= '0;
            out_bd    <= 1'b0;
            stall_cnt <= '0;
        end else if (en && flush) begin
            // Bubble keeps PC/BD so a later exception can still report an EPC.
            out_valid <= 1'b0;
            out_pc    <= in_pc;
            out_data  <= '0;
            out_exc   <= '0;
            out_bd    <= in_bd;
            stall_cnt <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_pc    <= in_pc;
            out_data  <= in_valid ? in_data : '0;
            out_exc   <= load_exc;
            out_bd    <= in_bd;
            stall_cnt <= '0;
        end else if (out_valid && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CW'(1);
        end
    end

    assign out_pcp8 = out_pc + 32'h0000_0008;

endmodule

// File: tb/tb_pipe_reg.sv
// Self-checking bench for pipe_reg: directed scenarios plus randomized traffic
// compared against a behavioural model of the stage register.
module tb_pipe_reg;

    localparam int unsigned DW    = 32;
    localparam int unsigned EXC_W = 5;
    localparam int unsigned CW    = 4;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             en, flush, req, in_valid, in_bd;
    logic [31:0]      in_pc;
    logic [DW-1:0]    in_data;
    logic [EXC_W-1:0] in_exc, new_exc;
    logic             out_valid, out_bd;
    logic [31:0]      out_pc, out_pcp8;
    logic [DW-1:0]    out_data;
    logic [EXC_W-1:0] out_exc;
    logic [CW-1:0]    stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit          m_valid, m_bd;
    bit [31:0]   m_pc;
    bit [DW-1:0] m_data;
    int          m_exc;
    int          m_cnt;

    pipe_reg #(.DW(DW), .EXC_W(EXC_W), .CW(CW)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .req(req),
        .in_valid(in_valid), .in_pc(in_pc), .in_data(in_data),
        .in_exc(in_exc), .new_exc(new_exc), .in_bd(in_bd),
        .out_valid(out_valid), .out_pc(out_pc), .out_data(out_data),
        .out_exc(out_exc), .out_bd(out_bd), .out_pcp8(out_pcp8),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_pc = 32'h0000_3000; m_data = '0; m_exc = 0; m_bd = 0; m_cnt = 0;
    endtask

    // One rising edge of the model, from the inputs currently applied.
    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else if (req) begin
            m_valid = 0; m_pc = 32'h0000_4180; m_data = '0; m_exc = 0; m_bd = 0; m_cnt = 0;
        end else if (en && flush) begin
            m_valid = 0; m_pc = in_pc; m_data = '0; m_exc = 0; m_bd = in_bd; m_cnt = 0;
        end else if (en) begin
            m_valid = in_valid; m_pc = in_pc; m_bd = in_bd; m_cnt = 0;
            if (in_valid) begin
                m_data = in_data;
                m_exc  = (in_exc != 0) ? int'(in_exc) : int'(new_exc);
            end else begin
                m_data = '0;
                m_exc  = 0;
            end
        end else if (m_valid) begin
            m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end
    endtask

    task automatic check_all(input string tag);
        longint pcp8;
        pcp8 = (longint'(m_pc) + 8) % 64'h1_0000_0000;
        chk({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
        chk({tag, ".pc"},    64'(out_pc),    64'(m_pc));
        chk({tag, ".data"},  64'(out_data),  64'(m_data));
        chk({tag, ".exc"},   64'(out_exc),   64'(m_exc));
        chk({tag, ".bd"},    64'(out_bd),    64'(m_bd));
        chk({tag, ".pcp8"},  64'(out_pcp8),  64'(pcp8));
        chk({tag, ".cnt"},   64'(stall_cnt), 64'(m_cnt));
    endtask

    // Apply current inputs across one edge and check 1 time unit later.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input bit e, input bit f, input bit r, input bit v,
                          input logic [31:0] pc, input logic [DW-1:0] d,
                          input int ie, input int ne, input bit bd);
        en = e; flush = f; req = r; in_valid = v; in_pc = pc; in_data = d;
        in_exc = EXC_W'(ie); new_exc = EXC_W'(ne); in_bd = bd;
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 0, 32'h0, '0, 0, 0, 0);
        model_reset();
        #3;
        check_all("reset");
        chk("reset_pc_const",   64'(out_pc),   64'h3000);
        chk("reset_pcp8_const", 64'(out_pcp8), 64'h3008);
        @(negedge clk);
        reset = 1'b0;

        // Basic load
        set_in(1, 0, 0, 1, 32'h3004, 32'h2408_0001, 0, 0, 0);
        cycle("load");
        chk("load_pcp8_const", 64'(out_pcp8), 64'h300C);
        chk("load_data_const", 64'(out_data), 64'h2408_0001);

        // Exception priority
        set_in(1, 0, 0, 1, 32'h3008, 32'h1111, 4, 10, 0);
        cycle("exc_old");
        chk("exc_old_const", 64'(out_exc), 64'd4);
        set_in(1, 0, 0, 1, 32'h300C, 32'h2222, 0, 10, 0);
        cycle("exc_new");
        chk("exc_new_const", 64'(out_exc), 64'd10);
        set_in(1, 0, 0, 0, 32'h3010, 32'h3333, 4, 10, 1);
        cycle("exc_invalid");
        chk("exc_invalid_const", 64'(out_exc), 64'd0);

        // Long stall saturates the counter, data held
        set_in(1, 0, 0, 1, 32'h3014, 32'hABCD_1234, 0, 0, 0);
        cycle("stall_load");
        set_in(0, 0, 0, 0, 32'hDEAD_BEEF, 32'h5555, 7, 7, 1);
        for (int i = 0; i < 20; i++) cycle("stall");
        chk("stall_sat_const", 64'(stall_cnt), 64'd15);
        chk("stall_data_const", 64'(out_data), 64'hABCD_1234);
        set_in(1, 0, 0, 1, 32'h3018, 32'h77, 0, 0, 0);
        cycle("stall_release");
        chk("stall_release_const", 64'(stall_cnt), 64'd0);

        // Flush keeps PC/BD; flush without en is a hold
        set_in(1, 1, 0, 1, 32'h3010, 32'h99, 3, 3, 1);
        cycle("flush");
        chk("flush_pc_const", 64'(out_pc), 64'h3010);
        chk("flush_bd_const", 64'(out_bd), 64'd1);
        set_in(0, 1, 0, 1, 32'h3020, 32'h98, 3, 3, 0);
        cycle("flush_hold");

        // Exception redirect overrides a load
        set_in(1, 0, 1, 1, 32'h3024, 32'h42, 6, 6, 1);
        cycle("req");
        chk("req_pc_const", 64'(out_pc), 64'h4180);

        // out_pcp8 wraps modulo 2^32
        set_in(1, 0, 0, 1, 32'hFFFF_FFFC, 32'h1, 0, 0, 0);
        cycle("wrap");
        chk("wrap_pcp8_const", 64'(out_pcp8), 64'h4);

        // Reset in the middle of a stall, then req on first edge after release
        set_in(1, 0, 0, 1, 32'h3100, 32'hCAFE, 0, 2, 0);
        cycle("mid_load");
        set_in(0, 0, 0, 0, 32'h0, '0, 0, 0, 0);
        cycle("mid_stall");
        cycle("mid_stall");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("mid_reset");
        chk("mid_reset_pc_const",    64'(out_pc),    64'h3000);
        chk("mid_reset_valid_const", 64'(out_valid), 64'd0);
        set_in(1, 0, 1, 1, 32'h3200, 32'h1, 1, 1, 1);
        cycle("reset_beats_req");
        @(negedge clk);
        reset = 1'b0;
        cycle("post_reset_req");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2,
                   $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                   $urandom, $urandom,
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 31)) : 0,
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 31)) : 0,
                   1'($urandom_range(0, 1)));
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
